// File: rtl/laser_pulse_gen.sv
// Laser shot sequencer: fires a configurable-width laser pulse, issues a delayed
// TDC start strobe tagged with a shot index, and enforces a post-pulse holdoff.
module laser_pulse_gen #(
  parameter int unsigned SYS_FREQ    = 125_000_000,
  parameter int unsigned HOLDOFF_NUM = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        send_en,
  input  logic        change_flag,
  input  logic [7:0]  pulse_width,
  input  logic [7:0]  tdc_delay,
  input  logic        zero_flag,
  output logic        laser_pulse,
  output logic        tdc_start,
  output logic [15:0] pulse_index,
  output logic        pulse_index_valid,
  output logic        busy,
  output logic [15:0] overrun_cnt
);

  localparam int unsigned CFG_W    = 8;
  localparam int unsigned IDX_W    = 16;
  localparam int unsigned HOLD_W   = 16;
  // Holdoff of zero or one both mean a single idle cycle; a zero clock rate is not a valid build.
  localparam int unsigned HOLD_CYC = (HOLDOFF_NUM > 1 && SYS_FREQ > 0) ? HOLDOFF_NUM : 1;

  localparam logic [2:0] IDLE    = 3'b001;
  localparam logic [2:0] PULSE   = 3'b010;
  localparam logic [2:0] HOLDOFF = 3'b100;

  logic [2:0]        state, state_nxt;
  logic              accept_c;
  logic [CFG_W-1:0]  sh_w, sh_d;
  logic [CFG_W-1:0]  wcnt, dcnt;
  logic [HOLD_W-1:0] hcnt;
  logic              tdc_pend;
  logic [IDX_W-1:0]  last_idx, cur_idx, shot_idx_c;
  logic              zs1, zs2, zs3, zero_pend, zero_rise_c;

  assign zero_rise_c = zs2 & ~zs3;
  assign shot_idx_c  = (zero_pend || zero_rise_c) ? '0 : last_idx + IDX_W'(1);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; HOLDOFF waits for both its minimum length and the shot's TDC strobe
  always_comb begin
    state_nxt = state;
    accept_c  = 1'b0;
    case (state)
      IDLE: begin
        if (send_en) begin
          state_nxt = PULSE;
          accept_c  = 1'b1;
        end
      end
      PULSE:   if (wcnt <= CFG_W'(1)) state_nxt = HOLDOFF;
      HOLDOFF: if (hcnt <= HOLD_W'(1) && !tdc_pend) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Zero-mark synchronizer and edge history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zs1 <= 1'b0;
      zs2 <= 1'b0;
      zs3 <= 1'b0;
    end else begin
      zs1 <= zero_flag;
      zs2 <= zs1;
      zs3 <= zs2;
    end
  end

  // Shot datapath: shadow config, pulse/delay/holdoff counters, indexing, overrun
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_w              <= CFG_W'(1);
      sh_d              <= '0;
      wcnt              <= '0;
      dcnt              <= '0;
      hcnt              <= '0;
      tdc_pend          <= 1'b0;
      last_idx          <= '1;
      cur_idx           <= '0;
      zero_pend         <= 1'b0;
      laser_pulse       <= 1'b0;
      tdc_start         <= 1'b0;
      pulse_index       <= '0;
      pulse_index_valid <= 1'b0;
      busy              <= 1'b0;
      overrun_cnt       <= '0;
    end else begin
      tdc_start         <= 1'b0;
      pulse_index_valid <= 1'b0;
      busy              <= (state_nxt != IDLE);

      if (change_flag) begin
        sh_w <= (pulse_width == '0) ? CFG_W'(1) : pulse_width;
        sh_d <= tdc_delay;
      end

      if (accept_c)         zero_pend <= 1'b0;
      else if (zero_rise_c) zero_pend <= 1'b1;

      if (send_en && state != IDLE && overrun_cnt != '1)
        overrun_cnt <= overrun_cnt + IDX_W'(1);

      if (accept_c) begin
        laser_pulse <= 1'b1;
        wcnt        <= sh_w;
        last_idx    <= shot_idx_c;
        cur_idx     <= shot_idx_c;
        if (sh_d == '0) begin
          tdc_start         <= 1'b1;
          pulse_index_valid <= 1'b1;
          pulse_index       <= shot_idx_c;
        end else begin
          tdc_pend <= 1'b1;
          dcnt     <= sh_d;
        end
      end else begin
        if (state == PULSE) begin
          if (wcnt <= CFG_W'(1)) begin
            laser_pulse <= 1'b0;
            hcnt        <= HOLD_W'(HOLD_CYC);
          end else begin
            wcnt <= wcnt - CFG_W'(1);
          end
        end
        if (state == HOLDOFF && hcnt > HOLD_W'(1))
          hcnt <= hcnt - HOLD_W'(1);
        if (tdc_pend) begin
          if (dcnt == CFG_W'(1)) begin
            tdc_start         <= 1'b1;
            pulse_index_valid <= 1'b1;
            pulse_index       <= cur_idx;
            tdc_pend          <= 1'b0;
          end else begin
            dcnt <= dcnt - CFG_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_laser_pulse_gen.sv
// Directed bench for laser_pulse_gen: shot shape, TDC timing, indexing, overrun, reset abort.
module tb_laser_pulse_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        send_en;
  logic        change_flag;
  logic [7:0]  pulse_width;
  logic [7:0]  tdc_delay;
  logic        zero_flag;
  logic        laser_pulse;
  logic        tdc_start;
  logic [15:0] pulse_index;
  logic        pulse_index_valid;
  logic        busy;
  logic [15:0] overrun_cnt;

  int vec_cnt  = 0;
  int miscomp  = 0;

  laser_pulse_gen #(.SYS_FREQ(125_000_000), .HOLDOFF_NUM(16)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .send_en           (send_en),
    .change_flag       (change_flag),
    .pulse_width       (pulse_width),
    .tdc_delay         (tdc_delay),
    .zero_flag         (zero_flag),
    .laser_pulse       (laser_pulse),
    .tdc_start         (tdc_start),
    .pulse_index       (pulse_index),
    .pulse_index_valid (pulse_index_valid),
    .busy              (busy),
    .overrun_cnt       (overrun_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscomp++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; we land 1 time unit after the edge, i.e. inside the next cycle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int w, input int d);
    change_flag = 1'b1;
    pulse_width = 8'(w);
    tdc_delay   = 8'(d);
    tick();
    change_flag = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 300) begin
      tick();
      n++;
    end
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  // Fire one shot and check laser shape, single TDC strobe at d+1, and index
  task automatic run_shot(input int w, input int d, input logic [15:0] idx, input string tag);
    int bad  = 0;
    int tdcs = 0;
    int len;
    len = ((w > d + 1) ? w : d + 1) + 2;
    send_en = 1'b1;
    tick();
    send_en = 1'b0;
    for (int k = 1; k <= len; k++) begin
      if (laser_pulse !== 1'(k <= w)) bad++;
      if (pulse_index_valid !== tdc_start) bad++;
      if (tdc_start === 1'b1) tdcs++;
      if (k == d + 1) begin
        chk({tag, "_tdc"}, 32'(tdc_start), 32'd1);
        chk({tag, "_idx"}, 32'(pulse_index), 32'(idx));
      end
      tick();
    end
    chk({tag, "_shape"}, 32'(bad), 32'd0);
    chk({tag, "_tdc_cnt"}, 32'(tdcs), 32'd1);
    wait_idle(tag);
    chk({tag, "_idx_hold"}, 32'(pulse_index), 32'(idx));
  endtask

  initial begin
    int bad;
    int tdcs;
    rst_n       = 1'b0;
    send_en     = 1'b0;
    change_flag = 1'b0;
    pulse_width = 8'd0;
    tdc_delay   = 8'd0;
    zero_flag   = 1'b0;
    repeat (3) tick();
    chk("rst_laser", 32'(laser_pulse), 32'd0);
    chk("rst_tdc", 32'(tdc_start), 32'd0);
    chk("rst_valid", 32'(pulse_index_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_idx", 32'(pulse_index), 32'd0);
    chk("rst_ovr", 32'(overrun_cnt), 32'd0);
    rst_n = 1'b1;
    repeat (3) tick();

    // Basic shot, width 0 clamp with zero delay, third shot
    cfg(5, 3);
    run_shot(5, 3, 16'd0, "w5d3");
    cfg(0, 0);
    run_shot(1, 0, 16'd1, "w0d0");
    cfg(4, 2);
    run_shot(4, 2, 16'd2, "w4d2");

    // Zero mark restarts the index sequence
    zero_flag = 1'b1;
    repeat (4) tick();
    zero_flag = 1'b0;
    repeat (4) tick();
    run_shot(4, 2, 16'd0, "zero_a");
    run_shot(4, 2, 16'd1, "zero_b");

    // Long delay keeps HOLDOFF alive; request at N+20 is dropped and counted
    cfg(2, 40);
    send_en = 1'b1;
    tick();
    bad  = 0;
    tdcs = 0;
    for (int k = 1; k <= 45; k++) begin
      if (laser_pulse !== 1'(k <= 2)) bad++;
      if (tdc_start === 1'b1) tdcs++;
      if (k == 41) begin
        chk("ovr_tdc", 32'(tdc_start), 32'd1);
        chk("ovr_idx", 32'(pulse_index), 32'd2);
        chk("ovr_busy41", 32'(busy), 32'd1);
      end
      if (k == 42) chk("ovr_busy42", 32'(busy), 32'd0);
      send_en = (k == 20);
      tick();
    end
    send_en = 1'b0;
    chk("ovr_shape", 32'(bad), 32'd0);
    chk("ovr_tdc_cnt", 32'(tdcs), 32'd1);
    chk("ovr_cnt", 32'(overrun_cnt), 32'd1);

    // Zero edge lands on the send_en cycle
    cfg(2, 1);
    zero_flag = 1'b1;
    tick();
    tick();
    run_shot(2, 1, 16'd0, "zsame_a");
    zero_flag = 1'b0;
    run_shot(2, 1, 16'd1, "zsame_b");

    // Config change mid-pulse must not disturb the shot in flight
    cfg(6, 2);
    send_en = 1'b1;
    tick();
    send_en = 1'b0;
    bad = 0;
    for (int k = 1; k <= 8; k++) begin
      if (laser_pulse !== 1'(k <= 6)) bad++;
      if (k == 3) begin
        chk("chg_tdc", 32'(tdc_start), 32'd1);
        chk("chg_idx", 32'(pulse_index), 32'd2);
      end
      change_flag = (k == 2);
      pulse_width = 8'd3;
      tdc_delay   = 8'd1;
      tick();
    end
    change_flag = 1'b0;
    chk("chg_shape", 32'(bad), 32'd0);
    wait_idle("chg");
    run_shot(3, 1, 16'd3, "chg_next");

    // Reset two cycles into a width-5 shot aborts it
    cfg(5, 3);
    send_en = 1'b1;
    tick();
    send_en = 1'b0;
    tick();
    chk("abort_pre", 32'(laser_pulse), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_laser", 32'(laser_pulse), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    tdcs = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (tdc_start === 1'b1) tdcs++;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (tdc_start === 1'b1 || laser_pulse === 1'b1) tdcs++;
    end
    chk("abort_no_tdc", 32'(tdcs), 32'd0);
    chk("abort_ovr", 32'(overrun_cnt), 32'd0);
    run_shot(1, 0, 16'd0, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscomp);
    $finish;
  end

endmodule
